// File: rtl/ddr2_calib_pkg.sv
// Shared DDR2 calibration definitions: FSM state encodings and the training
// pattern bytes, common to the write-side generator and the read-side comparator.
package ddr2_calib_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_DATA = 3'd2,
        WR_WAIT = 3'd3,
        RD_REQ  = 3'd4,
        RD_WAIT = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } calib_state_e;

    localparam logic [7:0] CALIB_PAT_A = 8'h55;
    localparam logic [7:0] CALIB_PAT_B = 8'hAA;

    // Even beats put A on the rising edge; odd beats swap the two bytes.
    function automatic logic [7:0] pat_rise(input logic odd_beat);
        return odd_beat ? CALIB_PAT_B : CALIB_PAT_A;
    endfunction

    function automatic logic [7:0] pat_fall(input logic odd_beat);
        return odd_beat ? CALIB_PAT_A : CALIB_PAT_B;
    endfunction

endpackage

// File: rtl/ddr2_pattern_gen8.sv
// Calibration pattern generator for one 8-bit DQS group: writes the training
// pattern once, then issues calibration reads until the comparator reports.
//
// state   | meaning
// IDLE    | waiting for init_done
// WR_REQ  | write command requested, waiting for cmd_ack
// WR_DATA | driving WR_BEATS beats of training pattern
// WR_WAIT | write recovery before the read
// RD_REQ  | read command requested, waiting for cmd_ack
// RD_WAIT | waiting for comparator result or timeout
// DONE    | calibration succeeded (sticky)
// ERROR   | calibration failed (sticky)
module ddr2_pattern_gen8
    import ddr2_calib_pkg::*;
#(
    parameter int WR_BEATS    = 2,
    parameter int WR_RECOVERY = 8,
    parameter int RD_TIMEOUT  = 32,
    parameter int MAX_RETRY   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_done,
    input  logic       cmd_ack,
    input  logic       comp_done,
    input  logic       comp_error,
    output logic       cmd_req,
    output logic       cmd_wr,
    output logic       ctrl_wren,
    output logic [7:0] wr_data_rise,
    output logic [7:0] wr_data_fall,
    output logic       calib_done,
    output logic       calib_error,
    output logic [3:0] retry_cnt
);

    localparam int CNT_MAX = (WR_RECOVERY > RD_TIMEOUT) ? WR_RECOVERY : RD_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BEAT_W  = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;

    localparam logic [CNT_W-1:0]  WR_WAIT_LOAD = CNT_W'(WR_RECOVERY - 1);
    localparam logic [CNT_W-1:0]  RD_WAIT_LOAD = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(WR_BEATS - 1);
    localparam logic [3:0]        LAST_RETRY   = 4'(MAX_RETRY - 1);

    calib_state_e      state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        retry, retry_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
        end
    end

    // Single down-counter: reloaded on entry to WR_WAIT and RD_WAIT, terminal at zero.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        case (state)
            IDLE: begin
                beat_nxt  = '0;
                cnt_nxt   = '0;
                retry_nxt = '0;
                if (init_done) state_nxt = WR_REQ;
            end
            WR_REQ: begin
                if (cmd_ack) begin
                    state_nxt = WR_DATA;
                    beat_nxt  = '0;
                end
            end
            WR_DATA: begin
                if (beat == LAST_BEAT) begin
                    state_nxt = WR_WAIT;
                    cnt_nxt   = WR_WAIT_LOAD;
                end else begin
                    beat_nxt = beat + BEAT_W'(1);
                end
            end
            WR_WAIT: begin
                if (cnt == '0) state_nxt = RD_REQ;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            RD_REQ: begin
                if (cmd_ack) begin
                    state_nxt = RD_WAIT;
                    cnt_nxt   = RD_WAIT_LOAD;
                end
            end
            RD_WAIT: begin
                if (comp_done) begin
                    state_nxt = DONE;
                end else if (comp_error) begin
                    state_nxt = ERROR;
                end else if (cnt == '0) begin
                    if (retry == LAST_RETRY) begin
                        state_nxt = ERROR;
                    end else begin
                        retry_nxt = retry + 4'd1;
                        state_nxt = RD_REQ;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase

        // Losing init mid-sequence restarts the whole calibration; results are kept.
        if (!init_done && state != DONE && state != ERROR) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end
    end

    assign cmd_req      = (state == WR_REQ) || (state == RD_REQ);
    assign cmd_wr       = (state == WR_REQ);
    assign ctrl_wren    = (state == WR_DATA);
    assign wr_data_rise = (state == WR_DATA) ? pat_rise(beat[0]) : 8'h00;
    assign wr_data_fall = (state == WR_DATA) ? pat_fall(beat[0]) : 8'h00;
    assign calib_done   = (state == DONE);
    assign calib_error  = (state == ERROR);
    assign retry_cnt    = retry;

endmodule

// File: tb/tb_ddr2_pattern_gen8.sv
// Scoreboard bench for ddr2_pattern_gen8: stimulus queues expected output events,
// a negedge monitor pops and compares them, including cycle gaps between events.
module tb_ddr2_pattern_gen8;

    localparam int EV_REQ  = 0;
    localparam int EV_BEAT = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int kind;
        int d0;
        int d1;
        int gap;   // cycles since previous event, -1 = don't care
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done = 1'b0;
    logic       cmd_ack = 1'b0;
    logic       comp_done = 1'b0;
    logic       comp_error = 1'b0;
    logic       cmd_req, cmd_wr, ctrl_wren, calib_done, calib_error;
    logic [7:0] wr_data_rise, wr_data_fall;
    logic [3:0] retry_cnt;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    logic req_q = 1'b0, done_q = 1'b0, err_q = 1'b0;

    ddr2_pattern_gen8 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_done    (init_done),
        .cmd_ack      (cmd_ack),
        .comp_done    (comp_done),
        .comp_error   (comp_error),
        .cmd_req      (cmd_req),
        .cmd_wr       (cmd_wr),
        .ctrl_wren    (ctrl_wren),
        .wr_data_rise (wr_data_rise),
        .wr_data_fall (wr_data_fall),
        .calib_done   (calib_done),
        .calib_error  (calib_error),
        .retry_cnt    (retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    wire [24:0] all_out = {cmd_req, cmd_wr, ctrl_wren, wr_data_rise, wr_data_fall,
                           calib_done, calib_error, retry_cnt};

    function automatic void push(input int kind, input int d0, input int d1, input int gap);
        ev_t e;
        e.kind = kind; e.d0 = d0; e.d1 = d1; e.gap = gap;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input int kind, input int d0, input int d1);
        ev_t e;
        int gap;
        gap = cyc - last_cyc;
        last_cyc = cyc;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d d0=%0h d1=%0h at cycle %0d, expected none",
                     kind, d0, d1, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.d0 != d0 || e.d1 != d1 || (e.gap >= 0 && e.gap != gap)) begin
                n_err++;
                $display("FAIL event: got kind=%0d d0=%0h d1=%0h gap=%0d, expected kind=%0d d0=%0h d1=%0h gap=%0d",
                         kind, d0, d1, gap, e.kind, e.d0, e.d1, e.gap);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            req_q = 1'b0; done_q = 1'b0; err_q = 1'b0;
            last_cyc = cyc;
        end else begin
            if (cmd_req && !req_q)        observe(EV_REQ, int'(cmd_wr), int'(retry_cnt));
            if (ctrl_wren)                observe(EV_BEAT, int'(wr_data_rise), int'(wr_data_fall));
            if (calib_done && !done_q)    observe(EV_DONE, int'(calib_error), int'(retry_cnt));
            if (calib_error && !err_q)    observe(EV_ERR, int'(calib_done), int'(retry_cnt));
            req_q = cmd_req; done_q = calib_done; err_q = calib_error;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!cmd_req && n < 300) begin
            step();
            n++;
        end
        if (!cmd_req) begin
            n_vec++; n_err++;
            $display("FAIL wait_req: cmd_req got 0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic ack(input int delay);
        wait_req();
        repeat (delay) step();
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
    endtask

    task automatic pulse_comp(input int k, input logic d, input logic e);
        repeat (k - 1) step();
        comp_done = d; comp_error = e;
        step();
        comp_done = 1'b0; comp_error = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_%s: %0d events still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; init_done = 1'b0; cmd_ack = 1'b0;
        comp_done = 1'b0; comp_error = 1'b0;
        step(); step();
        chk("reset_outputs", 32'(all_out), 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    // Write request, then beats (55,AA),(AA,55), then the read request after 8 idle cycles.
    task automatic push_write_seq(input int wr_gap, input int beat_gap);
        push(EV_REQ, 1, 0, wr_gap);
        push(EV_BEAT, 'h55, 'hAA, beat_gap);
        push(EV_BEAT, 'hAA, 'h55, 1);
        push(EV_REQ, 0, 0, 9);
    endtask

    initial begin
        int c0;

        // Nominal: done 10 cycles after the read ack.
        do_reset();
        push_write_seq(-1, 2);
        push(EV_DONE, 0, 0, 12);
        init_done = 1'b1;
        ack(1);
        ack(1);
        pulse_comp(10, 1'b1, 1'b0);
        drain("nominal");
        init_done = 1'b0;
        repeat (3) step();
        chk("done_sticky", 32'({calib_done, calib_error, cmd_req, retry_cnt}), 32'h40);

        // Backpressure on the write command, then comparator error.
        do_reset();
        push(EV_REQ, 1, 0, -1);
        push(EV_BEAT, 'h55, 'hAA, 21);
        push(EV_BEAT, 'hAA, 'h55, 1);
        push(EV_REQ, 0, 0, 9);
        push(EV_ERR, 0, 0, 4);
        init_done = 1'b1;
        wait_req();
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", 32'({cmd_req, cmd_wr, ctrl_wren}), 32'b110);
            step();
        end
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        ack(0);
        pulse_comp(3, 1'b0, 1'b1);
        drain("backpressure");
        chk("error_flags", 32'({calib_done, calib_error}), 32'b01);

        // Timeouts: 8 reads spaced by 32-cycle timeout, then error, no 9th read.
        do_reset();
        push(EV_REQ, 1, 0, -1);
        push(EV_BEAT, 'h55, 'hAA, 2);
        push(EV_BEAT, 'hAA, 'h55, 1);
        for (int i = 0; i < 8; i++) push(EV_REQ, 0, i, (i == 0) ? 9 : 33);
        push(EV_ERR, 0, 7, 33);
        init_done = 1'b1;
        ack(1);
        for (int i = 0; i < 8; i++) ack(0);
        drain("retry");
        repeat (40) step();
        chk("retry_final", 32'({cmd_req, calib_done, calib_error, retry_cnt}), 32'h17);

        // Simultaneous done and error: done wins.
        do_reset();
        push_write_seq(-1, 2);
        push(EV_DONE, 0, 0, 7);
        init_done = 1'b1;
        ack(1);
        ack(1);
        pulse_comp(5, 1'b1, 1'b1);
        drain("priority");
        repeat (3) step();
        chk("priority_flags", 32'({calib_done, calib_error}), 32'b10);

        // Abort during beat 1, restart from beat 0, then async reset mid-RD_WAIT.
        do_reset();
        push(EV_REQ, 1, 0, -1);
        push(EV_BEAT, 'h55, 'hAA, 2);
        push(EV_BEAT, 'hAA, 'h55, 1);
        init_done = 1'b1;
        ack(1);
        step();
        chk("abort_beat1", 32'({ctrl_wren, wr_data_rise}), 32'h1AA);
        init_done = 1'b0;
        step();
        chk("abort_idle", 32'(all_out), 32'h0);
        repeat (3) step();
        chk("abort_hold", 32'(all_out), 32'h0);
        drain("abort");
        push_write_seq(-1, 2);
        push(EV_REQ, 0, 1, 33);
        init_done = 1'b1;
        ack(1);
        ack(0);
        ack(0);
        drain("restart");
        repeat (5) step();
        chk("pre_reset_retry", 32'({ctrl_wren, cmd_req, retry_cnt}), 32'h1);
        c0 = cyc;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(all_out), 32'h0);
        chk("async_no_edge", 32'(cyc - c0), 32'h0);
        do_reset();

        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL leftover: %0d events pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr2_pattern_gen8.md
Name: ddr2_pattern_gen8

Overview:
- Write-side counterpart of the read-path pattern comparator for one 8-bit DQS group.
- After memory init, writes the fixed calibration training pattern into memory, then issues calibration reads repeatedly until the comparator reports done or error, or retries run out.
- Sits between the init sequencer and the controller command port; consumes comp_done/comp_error from the comparator.

Parameters:
- WR_BEATS, 2, clock cycles of write data per burst (2 = DDR burst of 4).
- WR_RECOVERY, 8, idle cycles between last write beat and the read request (tWR plus write-to-read margin).
- RD_TIMEOUT, 32, cycles to wait after a read acknowledge for comp_done/comp_error.
- MAX_RETRY, 8, total read attempts before declaring error (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_done  in  1  memory init complete; level
- cmd_ack  in  1  controller accepts the current command
- comp_done  in  1  comparator found pattern
- comp_error  in  1  comparator failed
- cmd_req  out  1  command request
- cmd_wr  out  1  1 = write command, 0 = read command; valid while cmd_req
- ctrl_wren  out  1  write data valid
- wr_data_rise  out  8  rising-edge write data
- wr_data_fall  out  8  falling-edge write data
- calib_done  out  1  sticky success
- calib_error  out  1  sticky failure
- retry_cnt  out  4  read attempts issued minus one

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset is asynchronous and applies immediately in any state.
- Outputs are Moore, decoded from registered state and counters. No output has a combinational path from any input.
- Handshake: a command transfers on a rising edge where cmd_req=1 and cmd_ack=1. cmd_req stays high until the transfer, then drops on the next cycle. cmd_ack while cmd_req=0 is ignored.
- IDLE: when init_done=1, go to WR_REQ. cmd_req rises 1 cycle after init_done is sampled high.
- WR_REQ: cmd_req=1, cmd_wr=1. On transfer, go to WR_DATA with beat=0.
- WR_DATA: ctrl_wren=1 for exactly WR_BEATS cycles.
  - beat[0]=0 drives rise=8'h55, fall=8'hAA.
  - beat[0]=1 drives rise=8'hAA, fall=8'h55.
  - After beat WR_BEATS-1, go to WR_WAIT.
  - Outside WR_DATA, wr_data_rise/wr_data_fall = 8'h00.
- WR_WAIT: count WR_RECOVERY cycles, then go to RD_REQ.
- RD_REQ: cmd_req=1, cmd_wr=0. On transfer, go to RD_WAIT with timer=0.
- RD_WAIT, priority highest first:
  - comp_done: go to DONE.
  - comp_error: go to ERROR.
  - timer==RD_TIMEOUT-1 and retry_cnt==MAX_RETRY-1: go to ERROR.
  - timer==RD_TIMEOUT-1 otherwise: increment retry_cnt, go to RD_REQ. No rewrite of the pattern.
  - Otherwise increment timer.
  - Simultaneous comp_done with timeout or comp_error: done wins.
- DONE: calib_done=1 from the cycle after entry; sticky until reset.
- ERROR: calib_error=1 from the cycle after entry; sticky until reset.
- init_done falling in any state other than DONE/ERROR:
  - abort to IDLE next cycle; drop cmd_req/ctrl_wren; clear beat, timer and retry_cnt;
  - restart from WR_REQ when init_done returns.
- retry_cnt saturates at MAX_RETRY-1; it never wraps.
- calib_done and calib_error are never both 1.

Decomposition:
- Shared calibration package/include (ddr2_calib_pkg): state encodings (IDLE, WR_REQ, WR_DATA, WR_WAIT, RD_REQ, RD_WAIT, DONE, ERROR) and the pattern constants 8'h55/8'hAA. The comparator uses the same constants.
- Single module; no sub-module.
- One shared down-counter serves WR_WAIT and RD_WAIT. It is reloaded on state entry.

Test Plan:
- Nominal:
  - stimulus: init_done=1 at t0; cmd_ack=1 one cycle after each cmd_req rises; comp_done pulsed 10 cycles after the read ack.
  - response: cmd_req at t0+1 with cmd_wr=1; ctrl_wren high for 2 cycles with (55,AA) then (AA,55); read cmd_req exactly 8 cycles after the last beat; calib_done=1 at +11; retry_cnt=0.
- Backpressure:
  - stimulus: cmd_ack held 0 for 20 cycles.
  - response: cmd_req and cmd_wr stable for all 20 cycles; no ctrl_wren until the ack.
- Retry/timeout:
  - stimulus: never assert comp_done/comp_error.
  - response: 8 read requests spaced by the 32-cycle timeout; retry_cnt reaches 7; calib_error=1; no 9th request.
- Priority:
  - stimulus: comp_done and comp_error high in the same cycle.
  - response: calib_done=1, calib_error=0.
- Abort:
  - stimulus: drop init_done during WR_DATA beat 1.
  - response: ctrl_wren=0 next cycle; state IDLE; on init_done reassert, the full write restarts from beat 0.
- Async reset:
  - stimulus: assert rst_n=0 mid-RD_WAIT between clock edges.
  - response: all outputs 0 immediately, without a clock edge.
